// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one CPU read/write onto an asynchronous EN/RW/MFC memory.
// Define MEMCTRL_TIMEOUT_EN to abort a stalled STROBE/RELEASE wait with a one-cycle Err pulse.
module mem_access_ctrl #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        WrReq,
  input  logic [15:0] ReqAddr,
  input  logic [15:0] ReqData,
  output logic        Busy,
  output logic        Done,
  output logic        Err,
  output logic [15:0] RdData,
  output logic        MemEN,
  output logic        MemRW,
  output logic [15:0] MemAddr,
  output logic [15:0] MemDataOut,
  input  logic [15:0] MemDataIn,
  input  logic        MemMFC
);

  localparam int unsigned SW = $clog2(SETUP_CYC + 1);
  localparam logic [SW-1:0] SETUP_LOAD = SW'(SETUP_CYC);
  localparam logic [SW-1:0] SETUP_ONE  = SW'(1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] setup_cnt_q, setup_cnt_d;
  logic          mfc_meta_q;
  logic          mfc_s;
  logic          abort;
  logic          mem_en_q, mem_en_d;
  logic          mem_rw_q, mem_rw_d;
  logic [15:0]   mem_addr_q, mem_addr_d;
  logic [15:0]   mem_dout_q, mem_dout_d;
  logic [15:0]   rd_data_q, rd_data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  // First MFC stage; every register that consumes mfc_s acts as the second stage,
  // so an MFC level change takes effect on the second edge after it arrives.
  assign mfc_s = mfc_meta_q;

`ifdef MEMCTRL_TIMEOUT_EN
  localparam int unsigned TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          waiting;

  assign waiting = ((state_q == STROBE) && !mfc_s) || ((state_q == RELEASE) && mfc_s);
  assign abort   = waiting && (to_cnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    to_cnt_d = '0;
    if ((state_q == STROBE || state_q == RELEASE) && (state_d == state_q))
      to_cnt_d = to_cnt_q + TW'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end
`else
  // Waits are unbounded; the parameter only matters when the timeout is built in.
  assign abort = (TIMEOUT == 0) && 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      setup_cnt_q <= '0;
      mfc_meta_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= 1'b1;
      mem_addr_q  <= '0;
      mem_dout_q  <= '0;
      rd_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
      mfc_meta_q  <= MemMFC;
      mem_en_q    <= mem_en_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_dout_q  <= mem_dout_d;
      rd_data_q   <= rd_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // NOTE: each always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (Req) begin
          state_d     = SETUP;
          setup_cnt_d = SETUP_LOAD;
        end
      end
      SETUP: begin
        setup_cnt_d = setup_cnt_q - SETUP_ONE;
        if (setup_cnt_q == SETUP_ONE) state_d = STROBE;
      end
      STROBE:  if (mfc_s)  state_d = RELEASE;
      RELEASE: if (!mfc_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_comb begin
    mem_en_d   = (state_d == STROBE);
    busy_d     = (state_d != IDLE);
    done_d     = (state_q == RELEASE) && !mfc_s;
    err_d      = abort;
    mem_rw_d   = mem_rw_q;
    mem_addr_d = mem_addr_q;
    mem_dout_d = mem_dout_q;
    rd_data_d  = rd_data_q;
    if (state_q == IDLE && Req) begin
      mem_rw_d   = ~WrReq;
      mem_addr_d = ReqAddr;
      mem_dout_d = ReqData;
    end
    // Data is only sampled once the synchronized MFC is high, so it is settled.
    if (state_q == STROBE && mfc_s && mem_rw_q) rd_data_d = MemDataIn;
  end

  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Err        = err_q;
  assign RdData     = rd_data_q;
  assign MemEN      = mem_en_q;
  assign MemRW      = mem_rw_q;
  assign MemAddr    = mem_addr_q;
  assign MemDataOut = mem_dout_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: vector table plus hand-written multi-cycle sequences,
// against a behavioural EN/RW/MFC memory with programmable MFC delay.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset, req, req3, wr_req;
  logic [15:0] req_addr, req_data;

  logic        busy, done, err, mem_en, mem_rw;
  logic [15:0] rd_data, mem_addr, mem_dout, mem_din;
  logic        mfc = 1'b0;

  logic        busy3, done3, err3, mem_en3, mem_rw3;
  logic [15:0] rd_data3, mem_addr3, mem_dout3, mem_din3;
  logic        mfc3 = 1'b0;

  logic [15:0] mem_arr [0:65535];
  int          mfc_dly = 5;
  bit          mfc_en  = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.SETUP_CYC(1), .TIMEOUT(16)) u_dut (
    .Clk(clk), .Reset(reset), .Req(req), .WrReq(wr_req), .ReqAddr(req_addr), .ReqData(req_data),
    .Busy(busy), .Done(done), .Err(err), .RdData(rd_data),
    .MemEN(mem_en), .MemRW(mem_rw), .MemAddr(mem_addr), .MemDataOut(mem_dout),
    .MemDataIn(mem_din), .MemMFC(mfc)
  );

  mem_access_ctrl #(.SETUP_CYC(3)) u_dut3 (
    .Clk(clk), .Reset(reset), .Req(req3), .WrReq(wr_req), .ReqAddr(req_addr), .ReqData(req_data),
    .Busy(busy3), .Done(done3), .Err(err3), .RdData(rd_data3),
    .MemEN(mem_en3), .MemRW(mem_rw3), .MemAddr(mem_addr3), .MemDataOut(mem_dout3),
    .MemDataIn(mem_din3), .MemMFC(mfc3)
  );

  // Memory acts on the rising edge of EN and answers MFC after mfc_dly.
  assign mem_din = mem_arr[mem_addr];
  always @(posedge mem_en) begin
    if (!mem_rw) mem_arr[mem_addr] = mem_dout;
    #(mfc_dly);
    if (mfc_en) mfc = 1'b1;
  end
  always @(negedge mem_en) begin
    #(mfc_dly);
    mfc = 1'b0;
  end

  assign mem_din3 = 16'h3333;
  always @(posedge mem_en3) begin #5; mfc3 = 1'b1; end
  always @(negedge mem_en3) begin #5; mfc3 = 1'b0; end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one request and returns in the Done cycle; lat = -1 if Done never came.
  task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                         output int lat, output int rw_bad);
    lat    = -1;
    rw_bad = 0;
    @(negedge clk);
    req = 1'b1; wr_req = wr; req_addr = addr; req_data = data;
    @(negedge clk);
    req = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (mem_rw !== ~wr) rw_bad++;
      @(negedge clk);
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    int          dly;
    logic [15:0] exp_rd;
    int          exp_lat;
  } vec_t;

  initial begin
    vec_t        vecs [8];
    int          lat, rw_bad, n_done, n_err, err_at;
    logic [5:0]  en_exp, busy_exp, done_exp;

    for (int a = 0; a < 65536; a++) mem_arr[a] = 16'h0000;
    mem_arr[16'h0003] = 16'h00C3;
    mem_arr[16'h0009] = 16'h1234;

    vecs[0] = '{1'b0, 16'h0009, 16'h0000,  5, 16'h1234, 5};
    vecs[1] = '{1'b1, 16'h0020, 16'hBEEF,  5, 16'h1234, 5};
    vecs[2] = '{1'b0, 16'h0020, 16'h0000,  5, 16'hBEEF, 5};
    vecs[3] = '{1'b1, 16'h0100, 16'hA5A5,  5, 16'hBEEF, 5};
    vecs[4] = '{1'b0, 16'h0100, 16'h0000, 15, 16'hA5A5, 7};
    vecs[5] = '{1'b0, 16'h0003, 16'h0000,  5, 16'h00C3, 5};
    vecs[6] = '{1'b1, 16'hFFFF, 16'h5A5A, 15, 16'h00C3, 7};
    vecs[7] = '{1'b0, 16'hFFFF, 16'h0000,  5, 16'h5A5A, 5};

    // Reset held together with a request: reset must win.
    reset = 1'b1; req = 1'b1; req3 = 1'b0; wr_req = 1'b1;
    req_addr = 16'h0055; req_data = 16'h7777;
    repeat (3) @(negedge clk);
    check("rst_busy",   32'(busy),     0);
    check("rst_done",   32'(done),     0);
    check("rst_err",    32'(err),      0);
    check("rst_rddata", 32'(rd_data),  0);
    check("rst_memen",  32'(mem_en),   0);
    check("rst_memrw",  32'(mem_rw),   1);
    check("rst_addr",   32'(mem_addr), 0);
    check("rst_dout",   32'(mem_dout), 0);
    reset = 1'b0; req = 1'b0;
    @(negedge clk);
    check("rst_idle_busy", 32'(busy), 0);

    // Edge-by-edge reference read of 0x0009.
    en_exp   = 6'b000110;
    busy_exp = 6'b011111;
    done_exp = 6'b100000;
    req = 1'b1; wr_req = 1'b0; req_addr = 16'h0009; req_data = 16'h0000;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      req = 1'b0;
      check($sformatf("trace_en_e%0d", k),   32'(mem_en),   32'(en_exp[k]));
      check($sformatf("trace_busy_e%0d", k), 32'(busy),     32'(busy_exp[k]));
      check($sformatf("trace_done_e%0d", k), 32'(done),     32'(done_exp[k]));
      check($sformatf("trace_addr_e%0d", k), 32'(mem_addr), 'h0009);
      check($sformatf("trace_rw_e%0d", k),   32'(mem_rw),   1);
      check($sformatf("trace_rd_e%0d", k),   32'(rd_data),  (k >= 3) ? 'h1234 : 0);
    end

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      mfc_dly = vecs[i].dly;
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].data, lat, rw_bad);
      check($sformatf("vec%0d_latency", i), 32'(lat),         32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_rddata", i),  32'(rd_data),     32'(vecs[i].exp_rd));
      check($sformatf("vec%0d_rw_stable", i), 32'(rw_bad),    0);
      check($sformatf("vec%0d_addr", i),    32'(mem_addr),    32'(vecs[i].addr));
      check($sformatf("vec%0d_dout", i),    32'(mem_dout),    32'(vecs[i].data));
      check($sformatf("vec%0d_busy", i),    32'(busy),        0);
      check($sformatf("vec%0d_err", i),     32'(err),         0);
    end
    mfc_dly = 5;

    // Back-to-back: new request in the Done cycle, then a request while busy.
    run_txn(1'b0, 16'h0009, 16'h0000, lat, rw_bad);
    check("b2b_first_lat", 32'(lat), 5);
    req = 1'b1; wr_req = 1'b0; req_addr = 16'h0020; req_data = 16'h0000;
    @(negedge clk);
    check("b2b_accept_busy", 32'(busy),     1);
    check("b2b_accept_addr", 32'(mem_addr), 'h0020);
    check("b2b_done_pulse",  32'(done),     0);
    req = 1'b1; wr_req = 1'b1; req_addr = 16'h0030; req_data = 16'hDEAD;
    @(negedge clk);
    req = 1'b0;
    check("b2b_ignored_addr", 32'(mem_addr), 'h0020);
    check("b2b_ignored_rw",   32'(mem_rw),   1);
    n_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    check("b2b_done_count", 32'(n_done),               1);
    check("b2b_rddata",     32'(rd_data),              'hBEEF);
    check("b2b_no_write",   32'(mem_arr[16'h0030]),    0);
    check("b2b_idle",       32'(busy),                 0);

    // SETUP_CYC = 3 instance: strobe rises exactly three cycles after acceptance.
    @(negedge clk);
    req3 = 1'b1; wr_req = 1'b0; req_addr = 16'h0042; req_data = 16'h0000;
    lat = -1;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      req3 = 1'b0;
      if (k <= 4) check($sformatf("s3_en_e%0d", k), 32'(mem_en3), (k >= 3) ? 1 : 0);
      if (k <= 3) check($sformatf("s3_addr_e%0d", k), 32'(mem_addr3), 'h0042);
      if (done3 === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("s3_latency", 32'(lat),      7);
    check("s3_rddata",  32'(rd_data3), 'h3333);

    // Reset in STROBE: enable drops, nothing completes, read data cleared.
    @(negedge clk);
    req = 1'b1; wr_req = 1'b0; req_addr = 16'h0020; req_data = 16'h0000;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("mid_rst_strobe", 32'(mem_en), 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_en",   32'(mem_en),  0);
    check("mid_rst_busy", 32'(busy),    0);
    check("mid_rst_done", 32'(done),    0);
    check("mid_rst_err",  32'(err),     0);
    check("mid_rst_rd",   32'(rd_data), 0);
    reset = 1'b0;
    n_done = 0; n_err = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
      if (err === 1'b1) n_err++;
    end
    check("mid_rst_no_done", 32'(n_done), 0);
    check("mid_rst_no_err",  32'(n_err),  0);
    check("mid_rst_en_low",  32'(mem_en), 0);

    // Memory never answers.
    mfc_en = 1'b0;
    @(negedge clk);
    req = 1'b1; wr_req = 1'b0; req_addr = 16'h0009; req_data = 16'h0000;
    @(negedge clk);
    req = 1'b0;
    n_done = 0; n_err = 0; err_at = -1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
      if (err === 1'b1) begin
        n_err++;
        if (err_at < 0) err_at = c;
      end
    end
    check("nomfc_no_done", 32'(n_done), 0);
`ifdef MEMCTRL_TIMEOUT_EN
    check("nomfc_err_cycle", 32'(err_at),  17);
    check("nomfc_err_count", 32'(n_err),   1);
    check("nomfc_idle",      32'(busy),    0);
    check("nomfc_en_low",    32'(mem_en),  0);
    check("nomfc_rd_kept",   32'(rd_data), 0);
`else
    check("nomfc_still_busy", 32'(busy),   1);
    check("nomfc_no_err",     32'(n_err),  0);
    check("nomfc_en_high",    32'(mem_en), 1);
`endif

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Clocked memory-access controller placed directly upstream of the asynchronous EN/RW/MFC memory. It accepts single read/write requests from the CPU control unit, drives the memory's EN, RW, address and write-data lines with the required setup and strobe sequencing, and waits for the memory-function-complete (MFC) handshake. It then returns read data and a one-cycle completion pulse. The MFC input is asynchronous to Clk and is synchronized internally.

## Interface
- SETUP_CYC, 1: cycles address/RW/data are held with MemEN low before MemEN rises (≥1)
- TIMEOUT, 255: cycles allowed per wait phase before abort (only with the timeout macro)
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-high reset
- Req  in  1  request strobe; sampled only in IDLE
- WrReq  in  1  1 = write, 0 = read; sampled with Req
- ReqAddr  in  16  access address; sampled with Req
- ReqData  in  16  write data; sampled with Req
- Busy  out  1  high from the cycle after acceptance until Done/Err
- Done  out  1  one-cycle completion pulse
- Err  out  1  one-cycle timeout pulse
- RdData  out  16  last read data; held until the next read completes
- MemEN  out  1  memory enable strobe; the memory acts on its rising edge
- MemRW  out  1  1 = read, 0 = write
- MemAddr  out  16  memory address
- MemDataOut  out  16  write data to memory
- MemDataIn  in  16  read data from memory
- MemMFC  in  1  asynchronous memory-function-complete

## Operation
- States: IDLE, SETUP, STROBE, RELEASE.
- IDLE with Req=1: latch WrReq, ReqAddr and ReqData into MemRW (=~WrReq), MemAddr and MemDataOut. Go to SETUP. Load the setup counter with SETUP_CYC.
- SETUP: MemEN=0. Count down. At zero, go to STROBE.
- STROBE: MemEN=1. Wait for mfc_s=1, where mfc_s is MemMFC after a 2-flop synchronizer.
  - On mfc_s=1 with MemRW=1: capture MemDataIn into RdData.
  - On mfc_s=1: go to RELEASE.
- RELEASE: MemEN=0. Wait for mfc_s=0. Then pulse Done for one cycle and return to IDLE.
- MemAddr, MemRW and MemDataOut are stable from SETUP through RELEASE.
- Writes leave RdData unchanged.
- Req while Busy=1 is ignored. There is no queueing.
- Done is asserted in the first IDLE cycle, with Busy=0. A new Req is accepted in that same cycle.
- Reset values:
  - state IDLE, mfc_s synchronizer 0
  - MemEN 0, MemRW 1, MemAddr 0, MemDataOut 0
  - RdData 0, Busy 0, Done 0, Err 0
- Reset mid-transaction: MemEN drops at the next edge and nothing completes (no Done, no Err).
- Reset and Req in the same cycle: Reset wins.

## Timing
- Reference case: SETUP_CYC=1; MemMFC rises within one cycle of MemEN rising and falls within one cycle of MemEN falling.
  - Req accepted at edge 0.
  - MemEN high after edge 1.
  - mfc_s high at edge 3. RdData updated at edge 3. MemEN low after edge 3.
  - mfc_s low at edge 5. Done high for the cycle after edge 5.
  - Total latency: Done is 5 cycles after acceptance.
- Each extra SETUP_CYC adds one cycle.
- Each extra cycle of memory MFC delay adds one cycle.
- The synchronizer adds 2 cycles per MFC edge.
- MemDataOut and MemAddr settle at least SETUP_CYC cycles before MemEN rises.
- Read data is sampled only after mfc_s=1, so it is guaranteed stable.

## Configuration
- MEMCTRL_TIMEOUT_EN defined:
  - An 8-bit-or-wider cycle counter runs in STROBE and RELEASE, cleared on each state entry.
  - When the counter reaches TIMEOUT: MemEN goes to 0, Err pulses for 1 cycle, state goes to IDLE, and Done is not asserted.
  - RdData is unchanged.
- MEMCTRL_TIMEOUT_EN undefined:
  - No counter. Waits are unbounded.
  - Err is tied to 0.

## Test plan
- Read: memory holds 16'h1234 at 16'h0009. Req, WrReq=0, ReqAddr=16'h0009, MFC 5 ns after EN with a 10 ns clock -> Done 5 cycles after acceptance, RdData=16'h1234, MemRW=1 throughout.
- Write then read: write 16'hBEEF (any address outside the ROM range 0-7), then read the same address -> write Done leaves RdData unchanged; read returns 16'hBEEF.
- Back-to-back: Req asserted in the Done cycle -> accepted with no idle gap. A Req pulsed while Busy=1 -> ignored, exactly one transaction occurs.
- SETUP_CYC=3: MemEN rises exactly 3 cycles after acceptance, and MemAddr is stable for that whole window.
- Reset asserted during STROBE -> MemEN=0 and Busy=0 at the next edge; no Done, no Err; RdData=0.
- With MEMCTRL_TIMEOUT_EN and TIMEOUT=16, MemMFC held at 0 -> Err pulses 16 cycles after STROBE entry, no Done, controller back in IDLE. Without the macro, Busy stays high indefinitely.
